digit_editor: RTL

DIGIT_EDITOR -- requirements
Module: digit_editor

---
 rtl/digit_editor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/digit_editor.sv
// Eight-digit hex editor: buttons step the digit under the cursor or move the cursor; cursor digit blinks.
// Optional hold-to-repeat on inc/dec is compiled in with DIGIT_EDITOR_AUTO_REPEAT_EN.
module digit_editor #(
  parameter int unsigned BLINK_DIV    = 25000000,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  button_pulse,
  input  logic [3:0]  button_out,
  input  logic [15:0] SW_OK,
  output logic [31:0] disp_num,
  output logic [2:0]  cursor,
  output logic [7:0]  blink_mask,
  output logic [7:0]  point_out
);

  localparam logic [31:0] BLINK_LAST = BLINK_DIV - 1;

  logic        edit, clr, act;
  logic        rep_step, rep_dir_dec;
  logic        do_inc, do_dec, do_left, do_right, touched;
  logic [3:0]  digit_cur;
  logic [31:0] disp_nxt;
  logic [2:0]  cursor_nxt;
  logic [31:0] blink_cnt, blink_cnt_nxt;
  logic        phase, phase_nxt;

  assign edit      = SW_OK[0];
  assign clr       = SW_OK[1];
  assign act       = edit & ~clr;
  assign digit_cur = disp_num[{cursor, 2'b00} +: 4];

`ifdef DIGIT_EDITOR_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  localparam logic [31:0] DELAY_LAST = REPEAT_DELAY - 1;
  localparam logic [31:0] RATE_LAST  = REPEAT_RATE - 1;

  rep_state_t  state, state_nxt;
  logic [31:0] rep_cnt, rep_cnt_nxt;
  logic        rep_dec_q, rep_dec_nxt;
  logic        start, held;
  logic [11:0] unused_sw;

  assign unused_sw   = SW_OK[15:4] | {10'd0, SW_OK[3:2]};
  assign start       = act & (button_pulse[0] | button_pulse[1]);
  assign held        = (button_out == (rep_dec_q ? 4'b0010 : 4'b0001));
  assign rep_dir_dec = rep_dec_q;

  always_comb begin
    state_nxt   = state;
    rep_cnt_nxt = rep_cnt;
    rep_dec_nxt = rep_dec_q;
    rep_step    = 1'b0;
    if (start) begin
      state_nxt   = DELAY;
      rep_cnt_nxt = '0;
      rep_dec_nxt = ~button_pulse[0];
    end else if (state != IDLE && (!held || !act)) begin
      state_nxt   = IDLE;
      rep_cnt_nxt = '0;
    end else begin
      case (state)
        DELAY: begin
          // First repeat step fires on entry; later steps every REPEAT_RATE cycles.
          if (rep_cnt == DELAY_LAST) begin
            state_nxt   = REPEAT;
            rep_cnt_nxt = '0;
            rep_step    = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + 32'd1;
          end
        end
        REPEAT: begin
          if (rep_cnt == RATE_LAST) begin
            rep_cnt_nxt = '0;
            rep_step    = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rep_cnt   <= '0;
      rep_dec_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rep_cnt   <= rep_cnt_nxt;
      rep_dec_q <= rep_dec_nxt;
    end
  end
`else
  logic [15:0] unused_in;

  assign unused_in   = {SW_OK[15:2], REPEAT_DELAY[0], REPEAT_RATE[0]} ^ {12'd0, button_out};
  assign rep_step    = 1'b0;
  assign rep_dir_dec = 1'b0;
`endif

  always_comb begin
    do_inc   = 1'b0;
    do_dec   = 1'b0;
    do_left  = 1'b0;
    do_right = 1'b0;
    if (act) begin
      if (button_pulse[0])      do_inc   = 1'b1;
      else if (button_pulse[1]) do_dec   = 1'b1;
      else if (rep_step) begin
        do_inc = ~rep_dir_dec;
        do_dec = rep_dir_dec;
      end
      else if (button_pulse[2]) do_left  = 1'b1;
      else if (button_pulse[3]) do_right = 1'b1;
    end
  end

  assign touched = do_inc | do_dec | do_left | do_right;

  always_comb begin
    disp_nxt   = disp_num;
    cursor_nxt = cursor;
    if (clr)           disp_nxt = '0;
    else if (do_inc)   disp_nxt[{cursor, 2'b00} +: 4] = digit_cur + 4'd1;
    else if (do_dec)   disp_nxt[{cursor, 2'b00} +: 4] = digit_cur - 4'd1;
    else if (do_left)  cursor_nxt = cursor + 3'd1;
    else if (do_right) cursor_nxt = cursor - 3'd1;
  end

  // Any edit restarts the blink so the touched digit shows at once.
  always_comb begin
    blink_cnt_nxt = blink_cnt + 32'd1;
    phase_nxt     = phase;
    if (touched) begin
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nxt = '0;
      phase_nxt     = ~phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_num   <= '0;
      cursor     <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      blink_mask <= '0;
      point_out  <= '0;
    end else begin
      disp_num   <= disp_nxt;
      cursor     <= cursor_nxt;
      blink_cnt  <= blink_cnt_nxt;
      phase      <= phase_nxt;
      blink_mask <= (edit & phase_nxt) ? (8'd1 << cursor_nxt) : 8'd0;
      point_out  <= edit ? (8'd1 << cursor_nxt) : 8'd0;
    end
  end

endmodule
